// File: rtl/led_pattern_engine.sv
// led_pattern_engine: prescaled LED pattern generator with button-selected mode and colour routing
module led_pattern_engine #(
    parameter int N_LEDS = 4,
    parameter int CNT_W  = 32,
    parameter int DIV0   = 2**23,
    parameter int DIV1   = 2**24,
    parameter int DIV2   = 2**25,
    parameter int DIV3   = 2**26
) (
    input  logic              clock,
    input  logic              i_ck_reset,
    input  logic              i_enable,
    input  logic [1:0]        i_rate_sel,
    input  logic              i_dir,
    input  logic              i_btn_mode,
    input  logic              i_btn_color,
    output logic [N_LEDS-1:0] o_led,
    output logic [N_LEDS-1:0] o_led_r,
    output logic [N_LEDS-1:0] o_led_g,
    output logic [N_LEDS-1:0] o_led_b,
    output logic [1:0]        o_mode,
    output logic              o_tick
);
    localparam int KW = $clog2(N_LEDS + 1);
    localparam int PW = $clog2(N_LEDS);
    localparam logic [N_LEDS-1:0] ONE  = N_LEDS'(1);
    localparam logic [CNT_W-1:0]  LIM0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0]  LIM1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0]  LIM2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0]  LIM3 = CNT_W'(DIV3 - 1);

    typedef enum logic [1:0] {ROTATE, FLASH, PING, FILL} mode_t;

    mode_t             mode_q, mode_d;
    logic [2:0]        mode_sync, color_sync;
    logic [CNT_W-1:0]  cnt, cnt_d, lim;
    logic              tick, hit, mode_p, color_p;
    logic [1:0]        col, col_d;
    logic [N_LEDS-1:0] led_q, led_d, fill_up, fill_dn;
    logic [PW-1:0]     pos, pos_d, pos_inc;
    logic              up, up_d, up_inc, pp_top, pp_bot;
    logic [KW-1:0]     k, k_d, k_inc;

    assign lim = (i_rate_sel == 2'd0) ? LIM0 : (i_rate_sel == 2'd1) ? LIM1 :
                 (i_rate_sel == 2'd2) ? LIM2 : LIM3;
    // >= rather than == so shrinking the divider mid-count can never run past the limit
    assign hit     = i_enable && (cnt >= lim);
    assign mode_p  = mode_sync[1] & ~mode_sync[2];
    assign color_p = color_sync[1] & ~color_sync[2];

    assign pp_top  = up && (pos == PW'(N_LEDS - 1));
    assign pp_bot  = !up && (pos == '0);
    assign pos_inc = pp_top ? PW'(N_LEDS - 2) : pp_bot ? PW'(1) : up ? pos + PW'(1) : pos - PW'(1);
    assign up_inc  = pp_top ? 1'b0 : pp_bot ? 1'b1 : up;
    assign k_inc   = (k == KW'(N_LEDS)) ? '0 : k + KW'(1);

    // thermometer of the next fill level, both from the LSB and mirrored from the MSB
    always_comb begin
        fill_up = '0;
        fill_dn = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            fill_up[i]            = KW'(i) < k_inc;
            fill_dn[N_LEDS-1-i]   = KW'(i) < k_inc;
        end
    end

    // next state: a mode pulse wins over a tick and reloads the new mode's start pattern
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        pos_d  = pos;
        up_d   = up;
        k_d    = k;
        cnt_d  = (mode_p || hit) ? '0 : i_enable ? cnt + CNT_W'(1) : cnt;
        col_d  = color_p ? col + 2'd1 : col;
        if (mode_p) begin
            mode_d = mode_t'(mode_q + 2'd1);
            led_d  = (mode_d == ROTATE || mode_d == PING) ? ONE : '0;
            pos_d  = '0;
            up_d   = 1'b1;
            k_d    = '0;
        end else if (hit) begin
            case (mode_q)
                ROTATE: led_d = i_dir ? {led_q[0], led_q[N_LEDS-1:1]} : {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
                FLASH:  led_d = ~led_q;
                PING: begin
                    pos_d = pos_inc;
                    up_d  = up_inc;
                    led_d = ONE << pos_inc;
                end
                default: begin
                    k_d   = k_inc;
                    led_d = i_dir ? fill_dn : fill_up;
                end
            endcase
        end
    end

    // state registers, button synchronisers/edge flops and registered tick
    always_ff @(posedge clock) begin
        if (i_ck_reset) begin
            mode_sync  <= '0;
            color_sync <= '0;
            cnt        <= '0;
            tick       <= 1'b0;
            mode_q     <= ROTATE;
            col        <= 2'd0;
            led_q      <= ONE;
            pos        <= '0;
            up         <= 1'b1;
            k          <= '0;
        end else begin
            mode_sync  <= {mode_sync[1:0], i_btn_mode};
            color_sync <= {color_sync[1:0], i_btn_color};
            cnt        <= cnt_d;
            tick       <= hit;
            mode_q     <= mode_d;
            col        <= col_d;
            led_q      <= led_d;
            pos        <= pos_d;
            up         <= up_d;
            k          <= k_d;
        end
    end

    assign o_led   = led_q;
    assign o_mode  = mode_q;
    assign o_tick  = tick;
    assign o_led_r = (col == 2'd0 || col == 2'd3) ? led_q : '0;
    assign o_led_g = (col == 2'd1 || col == 2'd3) ? led_q : '0;
    assign o_led_b = col[1] ? led_q : '0;
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed checks of timing, patterns, buttons and reset
module tb_led_pattern_engine;
    logic       clock = 1'b0;
    logic       i_ck_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic [1:0] i_rate_sel = 2'd0;
    logic       i_dir = 1'b0;
    logic       i_btn_mode = 1'b0;
    logic       i_btn_color = 1'b0;
    logic [3:0] o_led, o_led_r, o_led_g, o_led_b;
    logic [1:0] o_mode;
    logic       o_tick;
    int         total = 0;
    int         bad = 0;

    led_pattern_engine #(.N_LEDS(4), .CNT_W(8), .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10)) dut (
        .clock(clock), .i_ck_reset(i_ck_reset), .i_enable(i_enable), .i_rate_sel(i_rate_sel),
        .i_dir(i_dir), .i_btn_mode(i_btn_mode), .i_btn_color(i_btn_color),
        .o_led(o_led), .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b),
        .o_mode(o_mode), .o_tick(o_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_tick(input string tag, input logic [3:0] exp);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!o_tick && n < 40);
        check({tag, "_tick"}, o_tick, 1);
        check(tag, o_led, exp);
    endtask

    task automatic press_mode();
        i_btn_mode = 1'b1;
        step(3);
        i_btn_mode = 1'b0;
    endtask

    task automatic press_color();
        i_btn_color = 1'b1;
        step(3);
        i_btn_color = 1'b0;
    endtask

    logic [3:0] pp_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic [3:0] fill_exp [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};
    logic [2:0] rgb_exp [4] = '{3'b010, 3'b001, 3'b111, 3'b100};

    initial begin
        int ticks;
        step(2);
        check("rst_led", o_led, 4'b0001);
        check("rst_mode", o_mode, 0);
        check("rst_tick", o_tick, 0);
        check("rst_rgb", {o_led_r, o_led_g, o_led_b}, 12'h100);

        i_ck_reset = 1'b0;
        i_enable = 1'b1;
        step(3);
        check("rot_pre_tick", o_tick, 0);
        check("rot_pre_led", o_led, 4'b0001);
        step(1);
        check("rot_t1_tick", o_tick, 1);
        check("rot_t1", o_led, 4'b0010);
        step(1);
        check("rot_pulse_len", o_tick, 0);
        wait_tick("rot_t2", 4'b0100);
        wait_tick("rot_t3", 4'b1000);
        wait_tick("rot_t4", 4'b0001);

        i_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(3);
            press_color();
            check($sformatf("col_r%0d", i), o_led_r, rgb_exp[i][2] ? 4'b0001 : 4'b0000);
            check($sformatf("col_g%0d", i), o_led_g, rgb_exp[i][1] ? 4'b0001 : 4'b0000);
            check($sformatf("col_b%0d", i), o_led_b, rgb_exp[i][0] ? 4'b0001 : 4'b0000);
        end
        check("col_led_kept", o_led, 4'b0001);

        i_enable = 1'b1;
        step(3);
        press_mode();
        check("m1_mode", o_mode, 1);
        step(3);
        press_mode();
        check("pp_mode", o_mode, 2);
        check("pp_init", o_led, 4'b0001);
        for (int i = 0; i < 8; i++) wait_tick($sformatf("pp%0d", i), pp_exp[i]);

        i_dir = 1'b1;
        step(3);
        press_mode();
        check("fill_mode", o_mode, 3);
        check("fill_init", o_led, 4'b0000);
        for (int i = 0; i < 5; i++) wait_tick($sformatf("fill%0d", i), fill_exp[i]);

        step(1);
        press_mode();
        check("coin_tick", o_tick, 1);
        check("coin_mode", o_mode, 0);
        check("coin_led", o_led, 4'b0001);
        step(3);
        check("coin_gap_tick", o_tick, 0);
        check("coin_gap_led", o_led, 4'b0001);
        step(1);
        check("coin_next_tick", o_tick, 1);
        check("coin_next_led", o_led, 4'b1000);

        i_rate_sel = 2'd3;
        step(3);
        press_mode();
        check("fl_mode", o_mode, 1);
        check("fl_init", o_led, 4'b0000);
        step(7);
        check("r3_no_tick", o_tick, 0);
        i_rate_sel = 2'd0;
        step(1);
        check("r0_tick", o_tick, 1);
        check("r0_led", o_led, 4'b1111);
        step(3);
        check("r0_gap", o_tick, 0);
        step(1);
        check("r0_tick2", o_tick, 1);
        check("r0_led2", o_led, 4'b0000);
        step(2);
        i_enable = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (o_tick) ticks++;
        end
        check("hold_ticks", ticks, 0);
        check("hold_led", o_led, 4'b0000);
        i_enable = 1'b1;
        step(1);
        check("resume_gap", o_tick, 0);
        step(1);
        check("resume_tick", o_tick, 1);
        check("resume_led", o_led, 4'b1111);

        step(3);
        press_color();
        step(3);
        press_mode();
        step(3);
        press_mode();
        check("rf_mode", o_mode, 3);
        wait_tick("rf_t1", 4'b1000);
        check("rf_g", o_led_g, 4'b1000);
        check("rf_r", o_led_r, 4'b0000);
        i_ck_reset = 1'b1;
        i_btn_mode = 1'b1;
        step(1);
        check("mid_rst_led", o_led, 4'b0001);
        check("mid_rst_mode", o_mode, 0);
        check("mid_rst_rgb", {o_led_r, o_led_g, o_led_b}, 12'h100);
        check("mid_rst_tick", o_tick, 0);
        step(1);
        i_ck_reset = 1'b0;
        i_btn_mode = 1'b0;
        step(3);
        check("rel_gap", o_tick, 0);
        check("rel_mode", o_mode, 0);
        step(1);
        check("rel_tick", o_tick, 1);
        check("rel_led", o_led, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameter N_LEDS, default 4, SHALL set the pattern width; legal range is 2..32.
REQ-002 Parameter CNT_W, default 32, SHALL set the prescaler counter width.
REQ-003 Parameters DIV0, DIV1, DIV2, DIV3, defaults 2**23, 2**24, 2**25, 2**26, SHALL set the tick periods in clocks; each SHALL be at least 2 and no more than 2**CNT_W.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_ck_reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 i_enable  in  1  SHALL let the prescaler run when high.
REQ-007 i_rate_sel  in  2  SHALL select DIV0..DIV3.
REQ-008 i_dir  in  1  SHALL set the shift direction: 0 is toward the MSB, 1 is toward the LSB.
REQ-009 i_btn_mode  in  1  SHALL advance the pattern mode; it is asynchronous to clock (raw button).
REQ-010 i_btn_color  in  1  SHALL advance the colour selection; it is asynchronous to clock (raw button).
REQ-011 o_led  out  N_LEDS  SHALL be the current pattern.
REQ-012 o_led_r, o_led_g, o_led_b  out  N_LEDS each  SHALL carry the pattern on the selected colour channel(s).
REQ-013 o_mode  out  2  SHALL show the current mode; o_tick  out  1  SHALL show the prescaler tick pulse.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser followed by a rising-edge detector, giving a one-cycle pulse per press; button-to-pulse latency is 3 clocks.
REQ-015 Prescaler behaviour:
- while i_enable=1, count increments each clock;
- when count >= DIVsel-1, o_tick SHALL be 1 for that cycle and count SHALL return to 0.
REQ-016 While i_enable=0, count SHALL hold and o_tick SHALL be 0.
REQ-017 Because the comparison is >=, a rate change to a smaller DIV SHALL never overrun.
REQ-018 The pattern SHALL change only in a cycle where o_tick=1, except on reset or a mode change.
REQ-019 Mode 0 (rotate):
- one-hot pattern, initial value 1;
- each tick rotates one place per i_dir;
- wraps MSB->LSB and LSB->MSB.
REQ-020 Mode 1 (flash): initial all-zeros; each tick inverts all bits.
REQ-021 Mode 2 (ping-pong):
- one-hot at position p, initial p=0, moving up;
- each tick p moves one place;
- at p=N_LEDS-1 moving up, the next tick SHALL give p=N_LEDS-2 moving down;
- at p=0 moving down, the next tick SHALL give p=1 moving up;
- i_dir is ignored.
REQ-022 Mode 3 (fill):
- thermometer count k, initial k=0, pattern = lowest k bits set;
- each tick k increments;
- after k=N_LEDS (all ones), the next tick SHALL give k=0.
- With i_dir=1 the pattern SHALL be bit-reversed (fills from the MSB).
REQ-023 On a mode-button pulse:
- mode SHALL advance 0->1->2->3->0;
- the new mode's initial pattern SHALL load on the same edge;
- the prescaler count SHALL clear to 0.
REQ-024 A mode pulse and a tick in the same cycle SHALL resolve as a mode change; the tick is discarded for the pattern, and o_tick still pulses.
REQ-025 On a colour-button pulse, the colour index SHALL advance 0(R)->1(G)->2(B)->3(white)->0.
REQ-026 Colour outputs:
- the selected channel(s) SHALL equal o_led, others 0;
- white drives all three channels;
- the colour change SHALL be visible the clock after the pulse;
- the pattern is unaffected.
REQ-027 A change on i_dir SHALL take effect on the next tick without reloading the pattern.
REQ-028 All outputs SHALL be registered or decoded only from registers, with no combinational path from any input.

Reset
REQ-029 While i_ck_reset=1 at a clock edge, the block SHALL set:
- mode=0, colour=0, pattern=1, count=0;
- ping-pong p=0 moving up, fill k=0;
- synchroniser and edge flops=0, o_tick=0.
REQ-030 Reset SHALL override every simultaneous event; the first tick after release SHALL occur DIVsel clocks after release with i_enable held high.
REQ-031 Reset asserted in the middle of any mode SHALL return the outputs to the reset values on the next edge.

Verification (N_LEDS=4, DIV0=4, DIV1=6, DIV2=8, DIV3=10)
REQ-032 Reset release, i_enable=1, rate 0, mode 0, i_dir=0: the block SHALL produce:
- o_tick at clocks 4, 8, 12, ...;
- o_led sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Ping-pong: after 2 mode presses, o_led per tick SHALL be 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-034 Fill with i_dir=1 (3 mode presses): o_led per tick SHALL be 0000, 1000, 1100, 1110, 1111, 0000.
REQ-035 A mode press timed so its pulse coincides with o_tick SHALL:
- give mode+1 with its initial pattern;
- leave count=0;
- cause no extra shift.
REQ-036 Switching rate 3->0 when count=7:
- the next cycle SHALL assert o_tick and the count SHALL clear;
- with i_enable=0 the count SHALL hold for 20 clocks with no tick.
REQ-037 Two colour presses SHALL route the pattern to o_led_b only; a fourth press SHALL return to o_led_r; reset asserted mid-fill SHALL restore o_led=0001, mode 0, colour R.
